// File: rtl/handshake_src_packer_pkg.sv
// Shared types and helpers for the handshake source packer and its word FIFO.
package handshake_src_packer_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitLow  = 2'd1,
        StWaitHigh = 2'd2
    } state_e;

    function automatic int unsigned bytes_per_word(input int unsigned width);
        return width / 8;
    endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO; same-cycle push and pop allowed, push into a full FIFO
// is only taken when a pop frees the slot on the same edge.
module sync_word_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_cnt,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == CNT_W'(DEPTH));
    assign o_cnt     = r_cnt;
    assign o_head    = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_cnt <= r_cnt + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

endmodule

// File: rtl/handshake_src_packer.sv
// Source-domain front end: packs bytes little-endian into words, buffers them and
// issues one word per sready/sidle handshake, holding din for the whole transaction.
module handshake_src_packer
    import handshake_src_packer_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    input  logic                     sidle,
    output logic                     sready,
    output logic [WIDTH-1:0]         din,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic [CNT_W-1:0]         sent_cnt
);

    localparam int unsigned BPW    = bytes_per_word(WIDTH);
    localparam int unsigned IDX_W  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned FCNT_W = $clog2(DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_part;
    logic [WIDTH-1:0]   w_word;
    logic               r_sready;
    logic [WIDTH-1:0]   r_din;
    logic [CNT_W-1:0]   r_sent_cnt;
    logic               r_busy;
    logic               w_accept;
    logic               w_last;
    logic               w_push;
    logic               w_pop;
    logic               w_launch;
    logic [WIDTH-1:0]   w_head;
    logic [FCNT_W-1:0]  w_fifo_cnt;
    logic [FCNT_W-1:0]  w_cnt_nxt;
    logic               w_full;
    logic               w_empty;

    sync_word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_word),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_cnt   (w_fifo_cnt),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Only the completing byte can stall; a same-edge pop frees the slot it needs.
    assign w_last   = (r_idx == LAST_IDX);
    assign in_ready = !(w_full && w_last) || w_pop;
    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && w_last;

    always_comb begin
        w_word = r_part;
        w_word[8*r_idx +: 8] = in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= '0;
            r_part <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_idx  <= '0;
                r_part <= '0;
            end else begin
                r_idx  <= r_idx + 1'b1;
                r_part <= w_word;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_pop       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty && sidle) begin
                    w_launch    = 1'b1;
                    w_state_nxt = StWaitLow;
                end
            end
            StWaitLow: begin
                if (!sidle) begin
                    w_state_nxt = StWaitHigh;
                end
            end
            StWaitHigh: begin
                if (sidle) begin
                    w_pop       = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign w_cnt_nxt = w_fifo_cnt + FCNT_W'(w_push) - FCNT_W'(w_pop);

    // The head is popped only at completion, so din keeps the launched word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_sready   <= 1'b0;
            r_din      <= '0;
            r_sent_cnt <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_sready <= w_launch;
            if (w_launch) begin
                r_din <= w_head;
            end
            if (w_pop) begin
                r_sent_cnt <= r_sent_cnt + 1'b1;
            end
            r_busy <= (w_state_nxt != StIdle) || (w_cnt_nxt != '0);
        end
    end

    assign sready   = r_sready;
    assign din      = r_din;
    assign busy     = r_busy;
    assign fifo_cnt = w_fifo_cnt;
    assign sent_cnt = r_sent_cnt;

endmodule

// File: tb/tb_handshake_src_packer.sv
// Directed bench for handshake_src_packer with a hand-driven synchronizer sidle.
module tb_handshake_src_packer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        sidle;
    logic        sready;
    logic [31:0] din;
    logic        busy;
    logic [2:0]  fifo_cnt;
    logic [3:0]  sent_cnt;

    int n_checks = 0;
    int n_errors = 0;

    handshake_src_packer #(
        .WIDTH (32),
        .DEPTH (4),
        .CNT_W (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .sidle    (sidle),
        .sready   (sready),
        .din      (din),
        .busy     (busy),
        .fifo_cnt (fifo_cnt),
        .sent_cnt (sent_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            int t;
            in_valid = 1'b1;
            in_data  = w[8*k +: 8];
            #1;
            t = 0;
            while (!in_ready && t < 50) begin
                tick();
                t++;
            end
            chk("push_ready", {31'd0, in_ready}, 32'd1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Synchronizer model: sidle drops for two cycles, then returns high.
    task automatic finish_txn();
        sidle = 1'b0;
        tick();
        chk("txn_sready_low", {31'd0, sready}, 32'd0);
        tick();
        sidle = 1'b1;
        tick();
    endtask

    function automatic logic [31:0] word_of(input int n);
        logic [7:0] b;
        b = 8'(16 * n);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    initial begin
        int          pulses;
        int          viol;
        int          wide;
        logic        prev;
        logic [31:0] d2;
        logic [3:0]  pat;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        sidle    = 1'b1;
        #12;
        chk("rst_sready", {31'd0, sready}, 32'd0);
        chk("rst_din", din, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_fifo_cnt", {29'd0, fifo_cnt}, 32'd0);
        chk("rst_sent_cnt", {28'd0, sent_cnt}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        tick();

        // Basic packing and launch latency.
        in_valid = 1'b1; in_data = 8'h11; tick();
        in_data = 8'h22; tick();
        in_data = 8'h33; tick();
        in_data = 8'h44; tick();
        in_valid = 1'b0;
        chk("t1_fifo_cnt1", {29'd0, fifo_cnt}, 32'd1);
        chk("t1_sready_pre", {31'd0, sready}, 32'd0);
        tick();
        chk("t1_sready", {31'd0, sready}, 32'd1);
        chk("t1_din", din, 32'h44332211);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("t1_sready_width", {31'd0, sready}, 32'd0);
        sidle = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_no_sready_low", {31'd0, sready}, 32'd0);
        end
        sidle = 1'b1;
        tick();
        chk("t1_sent_cnt", {28'd0, sent_cnt}, 32'd1);
        chk("t1_fifo_cnt0", {29'd0, fifo_cnt}, 32'd0);
        chk("t1_busy_done", {31'd0, busy}, 32'd0);

        // Backpressure with sidle held low, then in-order delivery.
        sidle = 1'b0;
        for (int w = 1; w <= 5; w++) begin
            for (int k = 0; k < 4; k++) begin
                in_valid = 1'b1;
                in_data  = 8'(16 * w + k);
                #1;
                if (w == 5 && k == 3) begin
                    chk("t2_stall_ready", {31'd0, in_ready}, 32'd0);
                    chk("t2_full_cnt", {29'd0, fifo_cnt}, 32'd4);
                end else begin
                    chk("t2_ready", {31'd0, in_ready}, 32'd1);
                    tick();
                end
            end
        end
        tick();
        tick();
        chk("t2_still_stalled", {31'd0, in_ready}, 32'd0);
        chk("t2_still_full", {29'd0, fifo_cnt}, 32'd4);
        chk("t2_no_launch", {31'd0, sready}, 32'd0);
        sidle = 1'b1;
        tick();
        chk("t2_sready_w1", {31'd0, sready}, 32'd1);
        chk("t2_din_w1", din, word_of(1));
        chk("t2_ready_wl", {31'd0, in_ready}, 32'd0);
        sidle = 1'b0;
        tick();
        tick();
        chk("t2_ready_wh", {31'd0, in_ready}, 32'd0);
        sidle = 1'b1;
        #1;
        chk("t2_ready_on_pop", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("t2_cnt_push_pop", {29'd0, fifo_cnt}, 32'd4);
        chk("t2_sent2", {28'd0, sent_cnt}, 32'd2);
        for (int n = 2; n <= 5; n++) begin
            tick();
            chk("t2_sready_n", {31'd0, sready}, 32'd1);
            chk("t2_din_order", din, word_of(n));
            finish_txn();
        end
        chk("t2_fifo_empty", {29'd0, fifo_cnt}, 32'd0);
        chk("t2_busy_done", {31'd0, busy}, 32'd0);
        chk("t2_sent6", {28'd0, sent_cnt}, 32'd6);

        // din stability while in_data toggles.
        push_word(32'hDEADBEEF);
        tick();
        chk("t3_sready", {31'd0, sready}, 32'd1);
        chk("t3_din_launch", din, 32'hDEADBEEF);
        sidle = 1'b0; in_data = 8'($urandom); tick();
        chk("t3_din_wl", din, 32'hDEADBEEF);
        in_data = 8'($urandom); tick();
        chk("t3_din_wh", din, 32'hDEADBEEF);
        sidle = 1'b1; in_data = 8'($urandom); tick();
        chk("t3_din_done", din, 32'hDEADBEEF);
        chk("t3_sent7", {28'd0, sent_cnt}, 32'd7);
        in_data = 8'($urandom); tick();
        chk("t3_din_retained", din, 32'hDEADBEEF);
        chk("t3_no_relaunch", {31'd0, sready}, 32'd0);

        // sidle pattern 1,0,0,1 repeated over two buffered words and one empty round.
        sidle = 1'b0;
        push_word(32'hCAFEF00D);
        push_word(32'h12345678);
        chk("t4_fifo_cnt2", {29'd0, fifo_cnt}, 32'd2);
        pulses = 0; viol = 0; wide = 0; prev = 1'b0; d2 = '0;
        pat = 4'b1001;
        for (int rep = 0; rep < 3; rep++) begin
            for (int p = 3; p >= 0; p--) begin
                sidle = pat[p];
                tick();
                if (sready) pulses++;
                if (sready && !sidle) viol++;
                if (sready && prev) wide++;
                if (sready && pulses == 2) d2 = din;
                prev = sready;
            end
        end
        chk("t4_pulses", 32'(pulses), 32'd2);
        chk("t4_sready_while_low", 32'(viol), 32'd0);
        chk("t4_pulse_width", 32'(wide), 32'd0);
        chk("t4_din_second", d2, 32'h12345678);
        chk("t4_sent9", {28'd0, sent_cnt}, 32'd9);
        chk("t4_fifo_empty", {29'd0, fifo_cnt}, 32'd0);

        // Asynchronous reset during WAIT_HIGH with two words buffered.
        sidle = 1'b0;
        push_word(32'h55555555);
        push_word(32'h66666666);
        sidle = 1'b1;
        tick();
        chk("t5_din_pre", din, 32'h55555555);
        sidle = 1'b0;
        tick();
        tick();
        chk("t5_busy_pre", {31'd0, busy}, 32'd1);
        chk("t5_cnt_pre", {29'd0, fifo_cnt}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_sready", {31'd0, sready}, 32'd0);
        chk("t5_rst_din", din, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_fifo_cnt", {29'd0, fifo_cnt}, 32'd0);
        chk("t5_rst_sent_cnt", {28'd0, sent_cnt}, 32'd0);
        #1;
        rst   = 1'b0;
        sidle = 1'b1;
        push_word(32'h04030201);
        tick();
        chk("t5_sready_after", {31'd0, sready}, 32'd1);
        chk("t5_din_after", din, 32'h04030201);
        finish_txn();
        chk("t5_sent1", {28'd0, sent_cnt}, 32'd1);
        chk("t5_fifo_empty", {29'd0, fifo_cnt}, 32'd0);

        // sent_cnt wrap 15 -> 0.
        for (int i = 0; i < 14; i++) begin
            push_word(32'h01010101 * 32'(i + 1));
            tick();
            finish_txn();
        end
        chk("t6_sent15", {28'd0, sent_cnt}, 32'd15);
        push_word(32'hA5A5_0F0F);
        tick();
        chk("t6_sready", {31'd0, sready}, 32'd1);
        finish_txn();
        chk("t6_sent_wrap", {28'd0, sent_cnt}, 32'd0);
        chk("t6_fifo_empty", {29'd0, fifo_cnt}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_din", din, 32'hA5A5_0F0F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/handshake_src_packer.md
Name: handshake_src_packer

Overview:
Source-domain (clk1) front end that feeds the handshake synchronizer.
- Accepts a byte stream with valid/ready and packs bytes little-endian into WIDTH-bit words.
- Buffers up to DEPTH words.
- Issues one word per handshake transaction on sready/din, paced by the synchronizer's sidle.
- Holds din stable for the whole transaction, because the destination samples din directly across domains.

Parameters:
WIDTH, 32, word width; must be a multiple of 8 and at least 8.
DEPTH, 4, word FIFO depth; must be a power of 2 and at least 2.
CNT_W, 16, width of sent_cnt.

Ports:
clk  input  1  source-domain clock (sclk side); all logic on its rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  in_data carries a byte.
in_data  input  8  byte payload.
in_ready  output  1  byte accepted on an edge where in_valid && in_ready.
sidle  input  1  synchronizer idle; reset value at the synchronizer is 1.
sready  output  1  single-cycle request pulse to the synchronizer.
din  output  WIDTH  word presented to the synchronizer.
busy  output  1  transaction in flight or FIFO non-empty.
fifo_cnt  output  $clog2(DEPTH)+1  words currently buffered.
sent_cnt  output  CNT_W  completed transactions; wraps modulo 2^CNT_W.

Behaviour:
Reset values (asynchronous, active-high):
- sready=0, din=0, busy=0, fifo_cnt=0, sent_cnt=0.
- Packer byte index 0, partial word cleared, FIFO empty, FSM in IDLE.
- Reset mid-transaction abandons the word; no resend after reset.

Packer:
- Byte k (0-based) of a word goes to bits [8k+7:8k].
- On acceptance of byte WIDTH/8-1, the completed word is pushed to the FIFO on that same edge.
- in_ready = !(fifo full && index == WIDTH/8-1). Partial bytes are always accepted; only the completing byte stalls when full.
- A pop on the same edge frees a slot combinationally: in_ready is also 1 when the FIFO is full, index == last, and a pop occurs this cycle.
- Simultaneous push and pop: fifo_cnt is unchanged and data order is preserved. Pointers wrap modulo DEPTH.

FSM states:
- IDLE: if fifo_cnt != 0 && sidle==1, register sready<=1 and din<=FIFO head, then go to WAIT_LOW. Otherwise stay.
- WAIT_LOW: sready<=0 unconditionally, so sready is exactly one cycle wide. Stay until sidle==0, then go to WAIT_HIGH.
- WAIT_HIGH: stay until sidle==1. On that edge: pop the FIFO, sent_cnt++, go to IDLE.
- din is written only in IDLE on launch. It is held through WAIT_LOW and WAIT_HIGH, and retains its value afterwards.
- sready is never asserted outside the IDLE→WAIT_LOW edge and never while sidle==0.
- A new launch may occur on the edge after returning to IDLE, if the FIFO is non-empty and sidle==1.

busy:
- busy = (state != IDLE) || (fifo_cnt != 0), registered.

Latency:
- Completing byte accepted at edge k gives fifo_cnt=1 after edge k.
- With sidle==1, sready=1 and din valid after edge k+1.

No combinational path from sidle to sready or din.

Decomposition:
- Shared package: FSM state encoding (IDLE, WAIT_LOW, WAIT_HIGH) and the BYTES_PER_WORD = WIDTH/8 localparam function.
- One sub-module: sync_word_fifo (single-clock FIFO with params WIDTH and DEPTH; push, pop, head, cnt, full, empty; same-cycle push/pop allowed).
- Packer and FSM live in the top.

Test Plan:
- WIDTH=32, sidle held 1, bytes 0x11,0x22,0x33,0x44 on consecutive cycles → sready pulses once, 1 cycle wide, one edge after the 0x44 accept edge, with din=0x44332211. Model sidle falling 2 cycles later and rising 6 cycles later → sent_cnt=1, fifo_cnt=0, busy=0.
- sidle held 0 while 5 words are streamed → fifo_cnt saturates at 4 and in_ready drops only on the 4th byte of word 5. Release sidle → word 5 is accepted on the same edge as the first pop, and words are delivered in order.
- Word 0xDEADBEEF launched, then in_data toggled randomly during WAIT_LOW and WAIT_HIGH → din stays 0xDEADBEEF until the next launch.
- sidle glitch pattern 1,0,0,1 with a non-empty FIFO → exactly one sready pulse per low-then-high sidle cycle, and no sready while sidle==0.
- rst asserted during WAIT_HIGH with 2 words buffered → all outputs return to reset values immediately (asynchronous). After release, new bytes 0x01..0x04 give din=0x04030201.
- sent_cnt preloaded near wrap (CNT_W=4, 16 transactions) → count goes 15→0 with no other side effect.
